// File: rtl/n64a_vtiming.sv
// n64a_vtiming -- N64 video sync decoder and video-mode detector.
//
// Decodes the multiplexed N64 video bus. A word with nVDSYNC low carries the
// sync bits; the next three words carry red, green and blue. From the sync
// words the block counts lines per field to detect PAL/NTSC and 240p/480i.
//
// Ports:
//   VCLK        in   video clock (only clock)
//   RST         in   synchronous active-high reset
//   nVDSYNC     in   low = VD_i holds a sync word
//   VD_i[3:0]   in   {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   data_cnt    out  colour phase: 01 red, 10 green, 11 blue, 00 idle
//   vmode       out  1 = PAL, 0 = NTSC
//   n64_480i    out  1 = interlaced source
//   vinfo_valid out  vmode / n64_480i are trustworthy
//   field_id    out  field parity (only driven with the option below)
//
// Optional feature: define N64A_VTIMING_FIELDID_EN to generate field_id from
// the line-count difference between consecutive fields. Without it the
// field_id port is tied to 0.

module n64a_vtiming (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       nVDSYNC,
  input  logic [3:0] VD_i,
  output logic [1:0] data_cnt,
  output logic       vmode,
  output logic       n64_480i,
  output logic       vinfo_valid,
  output logic       field_id
);

  localparam logic [9:0] LINE_MAX   = 10'd1023;
  localparam logic [9:0] PAL_THRESH = 10'd288;
  localparam logic [1:0] FALLS_OK   = 2'd2;

  logic       vsync_prev;
  logic       hsync_prev;
  logic [9:0] line_cnt;
  logic [9:0] line_cnt_last;
  logic [1:0] fall_cnt;

  logic       sync_word;
  logic       hsync_fall;
  logic       vsync_fall;
  logic [9:0] line_cnt_new;
  logic [1:0] fall_cnt_inc;
  logic       capture_sat;
  logic       valid_nxt;
  logic       pal_nxt;
  logic       interlace_nxt;
  logic [1:0] data_cnt_nxt;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == LINE_MAX) ? LINE_MAX : v + 10'd1;
  endfunction

  function automatic logic [1:0] sat_inc_falls(input logic [1:0] v);
    return (v >= FALLS_OK) ? FALLS_OK : v + 2'd1;
  endfunction

  always_comb begin
    sync_word    = ~nVDSYNC;
    hsync_fall   = sync_word & hsync_prev & ~VD_i[1];
    vsync_fall   = sync_word & vsync_prev & ~VD_i[3];
    // An HSYNC fall in the VSYNC-fall word still belongs to the ending field.
    line_cnt_new = hsync_fall ? sat_inc10(line_cnt) : line_cnt;
    fall_cnt_inc = sat_inc_falls(fall_cnt);
    // A saturated count means the field length is unknown; start over.
    capture_sat  = (line_cnt_new == LINE_MAX);
    valid_nxt    = ~capture_sat & (fall_cnt_inc == FALLS_OK);
    // Mode flags are held at 0 whenever the capture is not trustworthy.
    pal_nxt       = valid_nxt & (line_cnt_new > PAL_THRESH);
    interlace_nxt = valid_nxt & (line_cnt_new != line_cnt_last);

    data_cnt_nxt = 2'b00;
    if (sync_word) begin
      data_cnt_nxt = 2'b01;
    end else begin
      case (data_cnt)
        2'b01:   data_cnt_nxt = 2'b10;
        2'b10:   data_cnt_nxt = 2'b11;
        default: data_cnt_nxt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      data_cnt      <= 2'b00;
      vmode         <= 1'b0;
      n64_480i      <= 1'b0;
      vinfo_valid   <= 1'b0;
      line_cnt      <= 10'd0;
      line_cnt_last <= 10'd0;
      fall_cnt      <= 2'd0;
      vsync_prev    <= 1'b1;
      hsync_prev    <= 1'b1;
    end else begin
      data_cnt <= data_cnt_nxt;
      if (sync_word) begin
        vsync_prev <= VD_i[3];
        hsync_prev <= VD_i[1];
        if (vsync_fall) begin
          line_cnt      <= 10'd0;
          line_cnt_last <= line_cnt_new;
          fall_cnt      <= capture_sat ? 2'd1 : fall_cnt_inc;
          vinfo_valid   <= valid_nxt;
          vmode         <= pal_nxt;
          n64_480i      <= interlace_nxt;
        end else if (hsync_fall) begin
          line_cnt <= sat_inc10(line_cnt);
        end
      end
    end
  end

`ifdef N64A_VTIMING_FIELDID_EN
  // Interlaced fields alternate in length; the longer one is field 1.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      field_id <= 1'b0;
    end else if (vsync_fall) begin
      field_id <= interlace_nxt & (line_cnt_new > line_cnt_last);
    end
  end
`else
  assign field_id = 1'b0;
`endif

endmodule

// File: tb/tb_n64a_vtiming.sv
module tb_n64a_vtiming;

  logic       VCLK = 1'b0;
  logic       RST;
  logic       nVDSYNC;
  logic [3:0] VD_i;
  logic [1:0] data_cnt;
  logic       vmode;
  logic       n64_480i;
  logic       vinfo_valid;
  logic       field_id;

  n64a_vtiming dut (
    .VCLK        (VCLK),
    .RST         (RST),
    .nVDSYNC     (nVDSYNC),
    .VD_i        (VD_i),
    .data_cnt    (data_cnt),
    .vmode       (vmode),
    .n64_480i    (n64_480i),
    .vinfo_valid (vinfo_valid),
    .field_id    (field_id)
  );

  always #5 VCLK = ~VCLK;

  // Expected {data_cnt, vmode, n64_480i, vinfo_valid, field_id} per cycle.
  logic [5:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state, kept in plain integers.
  int m_since;   // words since the last sync word (capped)
  int m_lines;   // HSYNC falls since the last VSYNC fall / reset
  int m_last;    // previously captured field length
  int m_falls;   // VSYNC falls since reset (capped at 2)
  bit m_vp, m_hp, m_vm, m_i, m_val, m_fid;

  function automatic logic [1:0] phase_of(input int since);
    if (since == 0) return 2'b01;
    if (since == 1) return 2'b10;
    if (since == 2) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model(input bit rst, input bit nvd, input logic [3:0] vd);
    bit hf, vf;
    int newc;
    if (rst) begin
      m_since = 1000; m_lines = 0; m_last = 0; m_falls = 0;
      m_vp = 1; m_hp = 1; m_vm = 0; m_i = 0; m_val = 0; m_fid = 0;
    end else if (!nvd) begin
      m_since = 0;
      hf = m_hp && !vd[1];
      vf = m_vp && !vd[3];
      if (vf) begin
        newc = m_lines + (hf ? 1 : 0);
        if (newc > 1023) newc = 1023;
        if (newc == 1023) begin
          m_falls = 1;
          m_val   = 0;
        end else begin
          if (m_falls < 2) m_falls++;
          m_val = (m_falls == 2);
        end
        m_vm = m_val && (newc > 288);
        m_i  = m_val && (newc != m_last);
`ifdef N64A_VTIMING_FIELDID_EN
        m_fid = m_i && (newc > m_last);
`else
        m_fid = 0;
`endif
        m_last  = newc;
        m_lines = 0;
      end else if (hf) begin
        m_lines++;
      end
      m_hp = vd[1];
      m_vp = vd[3];
    end else begin
      if (m_since < 1000) m_since++;
    end
  endtask

  task automatic step(input bit rst, input bit nvd, input logic [3:0] vd);
    @(negedge VCLK);
    RST = rst; nVDSYNC = nvd; VD_i = vd;
    model(rst, nvd, vd);
    exp_q.push_back({phase_of(m_since), m_vm, m_i, m_val, m_fid});
  endtask

  task automatic sync_word(input bit vs, input bit hs);
    step(1'b0, 1'b0, {vs, 1'($urandom), hs, 1'($urandom)});
  endtask

  task automatic data_words(input int n);
    repeat (n) step(1'b0, 1'b1, 4'($urandom));
  endtask

  task automatic rnd_data();
    data_words($urandom_range(0, 4));
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      sync_word(1'b1, 1'b0); rnd_data();
      sync_word(1'b1, 1'b1); rnd_data();
    end
  endtask

  // One field of n lines ending in a VSYNC fall; coinc puts the last HSYNC
  // fall in the same word as the VSYNC fall.
  task automatic field(input int n, input bit coinc);
    lines(coinc ? n - 1 : n);
    if (coinc) sync_word(1'b0, 1'b0);
    else       sync_word(1'b0, 1'b1);
    rnd_data();
    sync_word(1'b0, 1'b1); rnd_data();
    sync_word(1'b1, 1'b1); rnd_data();
  endtask

  // Monitor: compares every registered output vector one step after issue.
  logic [5:0] m_exp, m_got;
  initial begin
    forever begin
      @(posedge VCLK);
      #1;
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_got = {data_cnt, vmode, n64_480i, vinfo_valid, field_id};
        n_vec++;
        if (m_got !== m_exp) begin
          n_fail++;
          $display("FAIL vec%0d t=%0t: got dc=%b vm=%b i=%b val=%b fid=%b, want dc=%b vm=%b i=%b val=%b fid=%b",
                   n_vec, $time, m_got[5:4], m_got[3], m_got[2], m_got[1], m_got[0],
                   m_exp[5:4], m_exp[3], m_exp[2], m_exp[1], m_exp[0]);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; nVDSYNC = 1'b1; VD_i = 4'hF;
    repeat (3) step(1'b1, 1'b1, 4'hF);

    // Colour phase: sync + 3 data + sync, then sync + 5 data + sync.
    sync_word(1'b1, 1'b1); data_words(3);
    sync_word(1'b1, 1'b1); data_words(5);
    sync_word(1'b1, 1'b1); data_words(2);

    // 240p NTSC, including a coincident HSYNC/VSYNC fall.
    repeat (3) field(263, 1'($urandom));
    field(263, 1'b1);

    // 480i PAL alternating field lengths.
    repeat (3) begin
      field(313, 1'($urandom));
      field(312, 1'($urandom));
    end

    // Reset mid-field, concurrent with a sync word carrying both falls.
    field(263, 1'b0);
    lines(100);
    step(1'b1, 1'b0, 4'h0);
    rnd_data();
    repeat (3) field(263, 1'($urandom));

    // Saturated line counter, then recovery.
    field(1030, 1'b0);
    repeat (3) field(263, 1'b0);
    data_words(6);

    @(posedge VCLK);
    #3;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
